fp_round_sched: RTL and testbench
=================================

Name: fp_round_sched

Overview:
- Shares one floor/ceil/trunc rounding datapath between N shader-lane requesters, using round-robin arbitration.
- Float format is 24 bits: sign [23], exponent [22:15] with bias 127, mantissa [14:0].
- Two-stage pipeline: arbitration/operand register, then rounding/result register. Full valid/ready backpressure.
- Results return to the response port tagged with the requester ID.
- Sits between lane issue logic and the writeback mux in the core FP cluster.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 24, float width; only 24 is supported.
- IDW, $clog2(NREQ), width of the response ID.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous active-high reset
- req_valid_i  input  NREQ  per-requester request valid
- req_ready_o  output  NREQ  per-requester accept; at most one bit high per cycle
- req_op_i  input  2*NREQ  per-requester op: 0 FLOOR, 1 CEIL, 2 TRUNC, 3 reserved (treated as TRUNC)
- req_data_i  input  WIDTH*NREQ  per-requester operand
- rsp_valid_o  output  1  result valid
- rsp_ready_i  input  1  consumer ready
- rsp_id_o  output  IDW  requester index of the result
- rsp_data_o  output  WIDTH  rounded result

Behaviour:
- Reset values (asynchronous on rst_i high):
  - Both stage valids 0, so rsp_valid_o = 0 and req_ready_o = 0.
  - Round-robin pointer 0; rsp_id_o = 0; rsp_data_o = 0.
- Stage 1 advance: S1 can accept when S1 is empty, or S2 will be empty or consumed this cycle.
  - S2 is consumed when rsp_valid_o && rsp_ready_i.
  - If S1 can accept, grant goes to the first valid requester at or after the pointer (wrapping modulo NREQ).
  - Only the granted requester sees req_ready_o high. The grant is purely combinational from req_valid_i and the pointer.
- Pointer update: on an accepted handshake the pointer becomes grantee+1, wrapping NREQ-1 to 0. With no handshake it holds.
- Latency: 2 cycles from request handshake to rsp_valid_o when there is no stall.
- Throughput: 1 op per cycle with rsp_ready_i held high.
- Stall: when rsp_ready_i is low, S2 holds its data stable and S1 fills.
  - Once both stages are full, all req_ready_o bits drop.
  - No data is lost or duplicated.
- Simultaneous events: a response consume and a new grant in the same cycle are both honoured. The pipeline shifts in lockstep.
- Rounding, computed between S1 and S2. Let e = operand[22:15].
  - e = 255 (inf/NaN) or e >= 142: output = input.
  - e < 127 (includes zero/subnormal), result by op and operand:
    - ±0 → unchanged.
    - TRUNC → signed zero.
    - FLOOR, positive → +0 (0x000000).
    - FLOOR, negative nonzero → -1.0 (0xBF8000).
    - CEIL, positive nonzero → +1.0 (0x3F8000).
    - CEIL, negative → -0 (0x800000).
  - 127 <= e < 142: the low 142-e mantissa bits are fraction bits and are cleared.
    - If any cleared bit was 1 and (FLOOR && sign) or (CEIL && !sign), add 1 at bit position 142-e to the 23-bit {exp,mant} field.
    - Carry into the exponent is correct by construction (-1.5 → -2.0).
- Reset mid-operation flushes both stages. In-flight ops are dropped; requesters reissue.

Optional Feature:
- Macro FP_ROUND_PERF_EN. When defined, two extra outputs are present:
  - perf_ops_o [31:0]: increments on each response handshake.
  - perf_stall_o [31:0]: increments each cycle rsp_valid_o && !rsp_ready_i.
  - Both counters wrap at 2^32, reset to 0, and saturate-free.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fp_pkg holds:
  - typedef fp24_t (struct: sign, exp[7:0], mant[14:0]).
  - enum round_op_e {ROP_FLOOR, ROP_CEIL, ROP_TRUNC, ROP_RSVD}.
  - Constants FP_BIAS = 127 and FP_MANT_W = 15.
- One sub-module, fp_round_core: purely combinational (fp24_t, round_op_e) → fp24_t, instantiated between S1 and S2.
- Arbiter and pipeline control stay in fp_round_sched.

Test Plan:
- Single requester 0, FLOOR 0x402000 (2.5), rsp_ready_i = 1:
  - rsp_valid_o high exactly 2 cycles after the handshake, data 0x400000, id 0.
  - FLOOR 0xC02000 (-2.5) → 0xC04000 (-3.0).
  - CEIL 0x402000 → 0x404000.
- Boundaries:
  - FLOOR 0xBFC000 (-1.5) → 0xC00000.
  - CEIL 0x3FC000 → 0x400000.
  - FLOOR 0xBE8000 (-0.25) → 0xBF8000.
  - TRUNC 0xBE8000 → 0x800000.
  - 0x7F8000 (inf) and e = 142 values pass unchanged.
- Round-robin: all 4 requesters valid continuously, rsp_ready_i = 1 → grants 0,1,2,3,0,… with rsp_id_o following the same order.
- Backpressure: rsp_ready_i low 5 cycles with requests pending → 2 ops buffered, req_ready_o all 0, rsp_data_o stable. On release, ordered drain with no loss or duplication.
- Reset while both stages are full → rsp_valid_o = 0 immediately and the pointer returns to 0. With FP_ROUND_PERF_EN, counters read 0, and after 3 stall cycles then 1 accept they read perf_stall_o = 3 and perf_ops_o = 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types for the fp24 floor/ceil/trunc rounding cluster.
// Format: sign[23], exp[22:15] (bias 127), mant[14:0].
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_MANT_W  = 15;
  localparam int FP_INT_EXP = FP_BIAS + FP_MANT_W;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FP_MANT_W-1:0] mant;
  } fp24_t;

  typedef enum logic [1:0] {
    ROP_FLOOR,
    ROP_CEIL,
    ROP_TRUNC,
    ROP_RSVD
  } round_op_e;

  function automatic logic rounds_away(round_op_e op, logic sign);
    return (op == ROP_FLOOR && sign) || (op == ROP_CEIL && !sign);
  endfunction

endpackage

// File: rtl/fp_round_sched_if.sv
// Lane request bundle and tagged response port of the rounding scheduler.
// master = lanes/writeback side, slave = scheduler.
interface fp_round_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24,
  parameter int IDW   = $clog2(NREQ)
);

  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [2*NREQ-1:0]     req_op_i;
  logic [WIDTH*NREQ-1:0] req_data_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [WIDTH-1:0]      rsp_data_o;

  modport master (
    output req_valid_i, req_op_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

endinterface

// File: rtl/fp_round_core.sv
// Combinational fp24 floor/ceil/trunc; reserved op behaves as trunc.
// Values with exp >= 142 (incl. inf/NaN) are already integral.
module fp_round_core
  import fp_pkg::*;
(
  input  fp24_t     i_a,
  input  round_op_e i_op,
  output fp24_t     o_y
);

  logic [3:0]           w_sh;
  logic [FP_MANT_W-1:0] w_mask;
  logic                 w_frac;
  logic                 w_up;
  logic                 w_zero;
  logic                 w_keep;
  logic                 w_tiny;
  logic [22:0]          w_field;
  logic [22:0]          w_sum;

  always_comb begin
    w_sh    = 4'(8'(FP_INT_EXP) - i_a.exp);
    w_mask  = (15'd1 << w_sh) - 15'd1;
    w_frac  = |(i_a.mant & w_mask);
    w_up    = rounds_away(i_op, i_a.sign);
    w_zero  = (i_a.exp == 8'd0) && (i_a.mant == '0);
    w_keep  = (i_a.exp >= 8'(FP_INT_EXP)) || w_zero;
    w_tiny  = (i_a.exp < 8'(FP_BIAS)) && !w_zero;
    w_field = {i_a.exp, i_a.mant} & ~{8'h00, w_mask};
    // carry out of the mantissa lands in the exponent on its own
    w_sum   = w_field + (23'd1 << w_sh);
  end

  always_comb begin
    o_y = i_a;
    unique case (1'b1)
      w_keep: o_y = i_a;
      w_tiny: begin
        unique case (i_op)
          ROP_FLOOR: o_y = i_a.sign ? fp24_t'(24'hBF8000)
                                    : fp24_t'(24'h000000);
          ROP_CEIL:  o_y = i_a.sign ? fp24_t'(24'h800000)
                                    : fp24_t'(24'h3F8000);
          default:   o_y = fp24_t'({i_a.sign, 23'd0});
        endcase
      end
      default: begin
        o_y = fp24_t'({i_a.sign,
                       (w_frac && w_up) ? w_sum : w_field});
      end
    endcase
  end

endmodule

// File: rtl/fp_round_sched.sv
// Round-robin share of one fp24 rounding datapath, 2-stage pipe.
// Optional perf counters under `define FP_ROUND_PERF_EN.
module fp_round_sched
  import fp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fp_round_sched_if.slave  bus
`ifdef FP_ROUND_PERF_EN
  ,
  output logic [31:0]      perf_ops_o,
  output logic [31:0]      perf_stall_o
`endif
);

  logic      r_s1_v;
  fp24_t     r_s1_d;
  round_op_e r_s1_op;
  logic [IDW-1:0] r_s1_id;
  logic      r_s2_v;
  fp24_t     r_s2_d;
  logic [IDW-1:0] r_s2_id;
  logic [IDW-1:0] r_ptr;

  logic      w_consume;
  logic      w_s2_load;
  logic      w_accept;
  logic      w_found;
  logic      w_hs;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW:0]   w_idx;
  round_op_e w_op;
  fp24_t     w_dat;
  fp24_t     w_rnd;

  assign w_consume = r_s2_v && bus.rsp_ready_i;
  assign w_s2_load = !r_s2_v || w_consume;
  assign w_accept  = !rst_i && (!r_s1_v || w_s2_load);

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (!w_found && bus.req_valid_i[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[IDW-1:0];
      end
    end
  end

  assign w_hs = w_accept && w_found;
  assign bus.req_ready_o = w_hs ? (NREQ'(1) << w_gnt_id) : '0;

  always_comb begin
    w_op  = ROP_FLOOR;
    w_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_op  = round_op_e'(bus.req_op_i[2*i +: 2]);
        w_dat = fp24_t'(bus.req_data_i[WIDTH*i +: WIDTH]);
      end
    end
  end

  fp_round_core u_core (
    .i_a  (r_s1_d),
    .i_op (r_s1_op),
    .o_y  (w_rnd)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_v  <= 1'b0;
      r_s1_d  <= '0;
      r_s1_op <= ROP_FLOOR;
      r_s1_id <= '0;
      r_s2_v  <= 1'b0;
      r_s2_d  <= '0;
      r_s2_id <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_s1_v <= w_hs;
        if (w_hs) begin
          r_s1_d  <= w_dat;
          r_s1_op <= w_op;
          r_s1_id <= w_gnt_id;
          r_ptr   <= (w_gnt_id == IDW'(NREQ-1)) ? '0
                                                : w_gnt_id + 1'b1;
        end
      end
      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_d  <= w_rnd;
          r_s2_id <= r_s1_id;
        end
      end
    end
  end

  assign bus.rsp_valid_o = r_s2_v;
  assign bus.rsp_id_o    = r_s2_id;
  assign bus.rsp_data_o  = WIDTH'(r_s2_d);

`ifdef FP_ROUND_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_consume) r_perf_ops <= r_perf_ops + 32'd1;
      if (r_s2_v && !bus.rsp_ready_i)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ops_o   = r_perf_ops;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_fp_round_sched.sv
// Randomized bench for fp_round_sched against a real-arithmetic model.
// Build with +define+FP_ROUND_PERF_EN to cover the perf counters.
module tb_fp_round_sched;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_round_sched_if #(.NREQ(N), .WIDTH(24), .IDW(2)) bus ();

`ifdef FP_ROUND_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  fp_round_sched #(.NREQ(N), .WIDTH(24), .IDW(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef FP_ROUND_PERF_EN
    ,
    .perf_ops_o   (perf_ops),
    .perf_stall_o (perf_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [23:0] d;
    int          age;
  } item_t;

  item_t       q[$];
  int          ptr;
  longint      m_ops;
  longint      m_stall;
  logic [N-1:0] seen_rdy;
  int          hs_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // reference: evaluate as a real number, round, re-encode
  function automatic logic [23:0] mround(int op, logic [23:0] x);
    logic   s;
    int     e;
    int     m;
    real    v;
    real    r;
    longint a;
    longint mm;
    int     k;
    s = x[23];
    e = int'(x[22:15]);
    m = int'(x[14:0]);
    if (e == 255 || e >= 142) return x;
    if (e == 0 && m == 0) return x;
    v = 1.0 + real'(m) / 32768.0;
    if (e >= 127) for (int i = 0; i < e - 127; i++) v = v * 2.0;
    else          for (int i = 0; i < 127 - e; i++) v = v / 2.0;
    if (s) v = -v;
    case (op)
      0:       r = $floor(v);
      1:       r = $ceil(v);
      default: r = (v < 0.0) ? $ceil(v) : $floor(v);
    endcase
    if (r == 0.0) return {s, 23'd0};
    a = longint'((r < 0.0) ? -r : r);
    k = 0;
    while ((64'sd1 <<< (k + 1)) <= a) k++;
    mm = ((a - (64'sd1 <<< k)) <<< 15) >>> k;
    return {(r < 0.0), 8'(k + 127), 15'(mm)};
  endfunction

  function automatic logic [23:0] rand_fp();
    logic [7:0]  e;
    logic [14:0] m;
    int          sel;
    sel = int'($urandom % 8);
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'(142 + $urandom % 3);
      default: e = 8'(120 + $urandom % 22);
    endcase
    m = ($urandom % 4 == 0) ? 15'(($urandom % 4) << 13)
                            : 15'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic flush_model();
    q.delete();
    ptr     = 0;
    m_ops   = 0;
    m_stall = 0;
  endtask

  // one cycle: inputs already driven; compare, update model, advance
  task automatic step();
    logic         ev;
    logic         acc;
    int           g;
    logic [N-1:0] erdy;
    #1;
    ev = (q.size() > 0) && (q[0].age >= 2);
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(bus.rsp_id_o), 64'(q[0].id));
      chk("rsp_data", 64'(bus.rsp_data_o), 64'(q[0].d));
    end
    acc  = (q.size() < 2) || (ev && bus.rsp_ready_i);
    g    = acc ? pick(bus.req_valid_i, ptr) : -1;
    erdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(bus.req_ready_o), 64'(erdy));
    seen_rdy = bus.req_ready_o;
`ifdef FP_ROUND_PERF_EN
    chk("perf_ops", 64'(perf_ops), 64'(m_ops[31:0]));
    chk("perf_stall", 64'(perf_stall), 64'(m_stall[31:0]));
`endif
    if (ev && bus.rsp_ready_i) begin
      void'(q.pop_front());
      m_ops++;
    end else if (ev) begin
      m_stall++;
    end
    if (g >= 0) begin
      q.push_back('{g, mround(int'(bus.req_op_i[2*g +: 2]),
                              bus.req_data_i[24*g +: 24]), 0});
      ptr = (g + 1) % N;
      hs_cnt++;
    end
    foreach (q[i]) q[i].age++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) begin
      bus.req_op_i[2*i +: 2]    = 2'($urandom);
      bus.req_data_i[24*i +: 24] = rand_fp();
    end
  endtask

  task automatic drain();
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (4) step();
  endtask

  task automatic single(input int op, input logic [23:0] x,
                        input logic [23:0] want);
    bus.req_valid_i      = 4'b0001;
    bus.req_op_i[1:0]    = 2'(op);
    bus.req_data_i[23:0] = x;
    bus.rsp_ready_i      = 1'b1;
    step();
    chk("single_grant", 64'(seen_rdy), 64'd1);
    bus.req_valid_i = '0;
    chk("lat_cycle1", 64'(bus.rsp_valid_o), 64'd0);
    step();
    chk("lat_cycle2", 64'(bus.rsp_valid_o), 64'd1);
    chk("single_data", 64'(bus.rsp_data_o), 64'(want));
    chk("single_id", 64'(bus.rsp_id_o), 64'd0);
    step();
  endtask

  int          v_op[11]  = '{0, 0, 1, 0, 1, 0, 2, 0, 1, 1, 3};
  logic [23:0] v_in[11]  = '{24'h402000, 24'hC02000, 24'h402000,
                             24'hBFC000, 24'h3FC000, 24'hBE8000,
                             24'hBE8000, 24'h7F8000, 24'h470001,
                             24'h000001, 24'hC02000};
  logic [23:0] v_out[11] = '{24'h400000, 24'hC04000, 24'h404000,
                             24'hC00000, 24'h400000, 24'hBF8000,
                             24'h800000, 24'h7F8000, 24'h470001,
                             24'h3F8000, 24'hC00000};

  initial begin
    bus.req_valid_i = '1;
    bus.req_op_i    = '0;
    bus.req_data_i  = '0;
    bus.rsp_ready_i = 1'b1;
    hs_cnt = 0;
    flush_model();
    #2;
    chk("rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_id", 64'(bus.rsp_id_o), 64'd0);
    chk("rst_data", 64'(bus.rsp_data_o), 64'd0);
`ifdef FP_ROUND_PERF_EN
    chk("rst_perf_ops", 64'(perf_ops), 64'd0);
    chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
    do_reset();

    for (int i = 0; i < 11; i++) begin
      chk("model_pin", 64'(mround(v_op[i], v_in[i])), 64'(v_out[i]));
      single(v_op[i], v_in[i], v_out[i]);
    end

    do_reset();
    bus.req_valid_i = '1;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_lanes();
      step();
      chk("rr_order", 64'(seen_rdy), 64'(N'(1) << (i % N)));
    end
    drain();

    bus.req_valid_i = '1;
    bus.rsp_ready_i = 1'b0;
    hs_cnt = 0;
    repeat (5) begin
      rand_lanes();
      step();
    end
    chk("bp_buffered", 64'(hs_cnt), 64'd2);
    chk("bp_ready_low", 64'(seen_rdy), 64'd0);
    chk("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) step();
    chk("bp_drained", 64'(bus.rsp_valid_o), 64'd0);

    bus.req_valid_i = '1;
    bus.rsp_ready_i = 1'b0;
    repeat (3) begin
      rand_lanes();
      step();
    end
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("midrst_ready", 64'(bus.req_ready_o), 64'd0);
    flush_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready_i = 1'b1;
    step();
    chk("ptr_after_rst", 64'(seen_rdy), 64'd1);
    drain();

`ifdef FP_ROUND_PERF_EN
    do_reset();
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0001;
    step();
    bus.req_valid_i = '0;
    step();
    repeat (3) step();
    bus.rsp_ready_i = 1'b1;
    step();
    chk("perf_stall_3", 64'(perf_stall), 64'd3);
    chk("perf_ops_1", 64'(perf_ops), 64'd1);
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid_i = N'($urandom);
      bus.rsp_ready_i = ($urandom % 10) < 7;
      rand_lanes();
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
